alu_stage: RTL
==============

# alu_stage

Parametrised, handshaked execute-stage ALU for the RISC-V pipeline. It performs the RV32I register/immediate ALU ops and AUIPC in one cycle, plus optional RV32M multiply/divide executed iteratively. Results, branch compare flags and a destination tag sit in a single-entry registered output slot with valid/ready flow control. The block sits between decode/operand-select and the memory stage, and supports a flush for branch redirect.

## Interface
- XLEN, 32, datapath width (≥8, even)
- PC_W, 32, width of pc_in (≤XLEN)
- TAG_W, 5, width of the pass-through tag (destination register index)
- MULDIV_EN, 1, 1 = ops 20–27 implemented; 0 = treated as unknown ops
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- flush  in  1  synchronous kill of in-flight op and output slot
- in_valid  in  1  operands/op valid
- in_ready  out  1  block can accept this cycle
- alu_op  in  6  operation code
- data_in_1  in  XLEN  operand A (rs1)
- data_in_2  in  XLEN  operand B (rs2 or immediate)
- pc_in  in  PC_W  instruction PC, zero-extended internally
- tag_in  in  TAG_W  tag captured with the op
- out_valid  out  1  output slot holds a result
- out_ready  in  1  downstream consumes result
- data_out  out  XLEN  result
- zero  out  1  A == B
- lt  out  1  signed A < B
- ltu  out  1  unsigned A < B
- tag_out  out  TAG_W  tag of the result
- busy  out  1  iterative mul/div in progress

## Operation
- Op codes: 0 ADD, 1 SUB, 2 XOR, 3 OR, 4 AND, 5 SLL, 6 SRL, 7 SRA (arithmetic), 8 SLT (signed), 9 SLTU, 10–18 immediate aliases of ADD, XOR, OR, AND, SLL, SRL, SRA, SLT, SLTU respectively, 19 AUIPC = pc_in + (B << 12) modulo 2^XLEN.
- 20 MUL (low XLEN), 21 MULH (s×s), 22 MULHSU (s×u), 23 MULHU (u×u), 24 DIV, 25 DIVU, 26 REM, 27 REMU.
- Shifts use B[log2(XLEN)-1:0] only.
- Unknown op (28–63, or 20–27 with MULDIV_EN=0): single-cycle, data_out = 0, flags still computed.
- Divide by zero: quotient all-ones; remainder = A. Signed overflow (most-negative / −1): quotient = A, remainder = 0. No exception.
- zero/lt/ltu computed from accepted A, B for every op, registered with data_out.
- States: IDLE, ITER (mul/div, counter 0..XLEN-1), DONE (slot full).
  - IDLE → DONE on accept of a single-cycle op; IDLE → ITER on accept of a mul/div op.
  - ITER → DONE after XLEN iterations.
  - DONE → IDLE on out_ready; DONE → DONE on out_ready with a simultaneous accept of a single-cycle op; DONE → ITER on out_ready with a simultaneous accept of a mul/div op.
- in_ready = !flush && state != ITER && (state == IDLE || out_ready).
- Signed mul/div: operate on magnitudes and fix the sign at the end; the output is a two's-complement XLEN result.

## Timing
- Reset (async): state IDLE, out_valid 0, busy 0, data_out 0, zero 0, lt 0, ltu 0, tag_out 0, in_ready 1 once reset is released.
- Accept occurs at the rising edge where in_valid && in_ready.
- Single-cycle op accepted at edge N: out_valid = 1 after edge N.
- Mul/div accepted at edge N: busy = 1 after edge N through edge N+XLEN; out_valid = 1 after edge N+XLEN+1, when busy drops.
- out_valid && !out_ready: data_out, flags and tag_out hold stable.
- Back-to-back single-cycle ops at full throughput when out_ready = 1.
- flush = 1 at an edge: state → IDLE, out_valid → 0, busy → 0, no accept that cycle. data_out keeps its last value.
- Reset asserted mid-iteration: the operation is abandoned and all outputs return to their reset values immediately.

## Test plan
- Reset then ADD 5 + 7 (op 0), out_ready = 1 → data_out = 12, zero = 0, lt = 1, ltu = 1, out_valid after one edge.
- SRA 0x80000000 by 4 (op 7) → 0xF8000000. SLT −1 vs 1 → 1. SLTU 0xFFFFFFFF vs 1 → 0. AUIPC pc_in = 0x100, B = 1 → 0x1100.
- MULH 0x80000000 × 0x80000000 → 0x40000000. DIV −7 / 2 → 0xFFFFFFFD. REM → 0xFFFFFFFF. Result appears exactly XLEN+1 edges after accept, busy high for XLEN edges, in_ready low throughout.
- DIVU 9 / 0 → 0xFFFFFFFF. REMU → 9. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000. REM → 0.
- Backpressure: out_ready = 0 for 3 cycles after XOR 0xF0 ^ 0x0F → data_out holds 0xFF with tag_out stable, in_ready low. Then raise out_ready together with a new in_valid: the new op is accepted in the same cycle.
- Assert flush at iteration 10 of a DIV → busy and out_valid are 0 the next cycle and no result emerges. Separately, assert reset mid-MUL → all outputs return to 0 asynchronously.

Source files
------------

// File: rtl/alu_stage.sv
// ---------------------------------------------------------------------------
// alu_stage
//   Execute-stage ALU for the RV32 pipeline. It handles the register and
//   immediate ALU ops and AUIPC in a single cycle. When MULDIV_EN is set it
//   also runs MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU as an iterative
//   shift-add or restoring-divide loop. Each result is held in a single-entry
//   output slot together with the A/B compare flags and the destination tag.
//   The slot uses valid/ready flow control.
//
// Parameters
//   XLEN      datapath width (>= 8, even)
//   PC_W      width of pc_in (<= XLEN), zero-extended internally
//   TAG_W     width of the pass-through destination tag
//   MULDIV_EN 1 = ops 20..27 run on the iterative unit, 0 = unknown ops
//
// Ports
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   flush                 synchronous kill of the in-flight op and the slot
//   in_valid / in_ready   operand handshake (alu_op, data_in_1/2, pc_in, tag_in)
//   out_valid / out_ready result-slot handshake
//   data_out, zero, lt, ltu, tag_out
//                         slot contents: result, A==B, signed A<B,
//                         unsigned A<B, and the captured tag
//   busy                  an iterative mul/div is in progress
// ---------------------------------------------------------------------------
module alu_stage #(
    parameter int XLEN      = 32,
    parameter int PC_W      = 32,
    parameter int TAG_W     = 5,
    parameter bit MULDIV_EN = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       alu_op,
    input  logic [XLEN-1:0]  data_in_1,
    input  logic [XLEN-1:0]  data_in_2,
    input  logic [PC_W-1:0]  pc_in,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  data_out,
    output logic             zero,
    output logic             lt,
    output logic             ltu,
    output logic [TAG_W-1:0] tag_out,
    output logic             busy
);

    localparam int SHW = $clog2(XLEN);
    localparam int CW  = $clog2(XLEN + 1);
    // The counter runs 0..XLEN-1 for the iterations proper. The extra value
    // XLEN is the sign-fix / write-back cycle.
    localparam logic [CW-1:0] FINAL_COUNT = CW'(XLEN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_nextState;

    logic                w_accept;
    logic                w_isMulDiv;
    logic [2:0]          w_mdSel;

    // Single-cycle datapath
    logic [SHW-1:0]      w_shamt;
    logic [XLEN-1:0]     w_pcExt;
    logic [XLEN-1:0]     w_aluRes;
    logic                w_zero;
    logic                w_lt;
    logic                w_ltu;

    // Iterative unit operand preparation
    logic                w_aSigned;
    logic                w_bSigned;
    logic                w_aNeg;
    logic                w_bNeg;
    logic [XLEN-1:0]     w_magA;
    logic [XLEN-1:0]     w_magB;

    // Iterative unit state
    logic [2*XLEN-1:0]   r_acc;
    logic [XLEN-1:0]     r_opM;
    logic [2:0]          r_mdSel;
    logic                r_negRes;
    logic                r_negA;
    logic                r_divZero;
    logic [CW-1:0]       r_count;
    logic                r_pZero;
    logic                r_pLt;
    logic                r_pLtu;
    logic [TAG_W-1:0]    r_pTag;

    // Iteration step and final result
    logic [XLEN-1:0]     w_hi;
    logic [XLEN-1:0]     w_lo;
    logic [XLEN:0]       w_mulSum;
    logic [2*XLEN-1:0]   w_mulNext;
    logic [XLEN:0]       w_remShift;
    logic [XLEN:0]       w_remDiff;
    logic [2*XLEN-1:0]   w_divNext;
    logic [2*XLEN-1:0]   w_prod;
    logic [XLEN-1:0]     w_quot;
    logic [XLEN-1:0]     w_rem;
    logic [XLEN-1:0]     w_mdRes;

    // Output slot
    logic [XLEN-1:0]     r_dataOut;
    logic                r_zero;
    logic                r_lt;
    logic                r_ltu;
    logic [TAG_W-1:0]    r_tag;

    assign w_accept   = in_valid && in_ready;
    assign w_isMulDiv = MULDIV_EN && (alu_op >= 6'd20) && (alu_op <= 6'd27);
    assign w_mdSel    = 3'(alu_op - 6'd20);

    // -----------------------------------------------------------------------
    // Single-cycle ALU and compare flags, evaluated on the incoming operands
    // -----------------------------------------------------------------------
    assign w_shamt = data_in_2[SHW-1:0];
    assign w_pcExt = XLEN'(pc_in);
    assign w_zero  = (data_in_1 == data_in_2);
    assign w_lt    = ($signed(data_in_1) < $signed(data_in_2));
    assign w_ltu   = (data_in_1 < data_in_2);

    always_comb begin
        w_aluRes = '0;
        case (alu_op)
            6'd0, 6'd10: w_aluRes = data_in_1 + data_in_2;
            6'd1:        w_aluRes = data_in_1 - data_in_2;
            6'd2, 6'd11: w_aluRes = data_in_1 ^ data_in_2;
            6'd3, 6'd12: w_aluRes = data_in_1 | data_in_2;
            6'd4, 6'd13: w_aluRes = data_in_1 & data_in_2;
            6'd5, 6'd14: w_aluRes = data_in_1 << w_shamt;
            6'd6, 6'd15: w_aluRes = data_in_1 >> w_shamt;
            6'd7, 6'd16: w_aluRes = $signed(data_in_1) >>> w_shamt;
            6'd8, 6'd17: w_aluRes = {{(XLEN-1){1'b0}}, w_lt};
            6'd9, 6'd18: w_aluRes = {{(XLEN-1){1'b0}}, w_ltu};
            6'd19:       w_aluRes = w_pcExt + (data_in_2 << 12);
            default:     w_aluRes = '0;
        endcase
    end

    // -----------------------------------------------------------------------
    // Mul/div operand setup: the loop works on magnitudes, so record which
    // operands are signed. The sign fix happens at write-back.
    // -----------------------------------------------------------------------
    always_comb begin
        w_aSigned = 1'b0;
        w_bSigned = 1'b0;
        case (w_mdSel)
            3'd1:       begin w_aSigned = 1'b1; w_bSigned = 1'b1; end
            3'd2:       begin w_aSigned = 1'b1; w_bSigned = 1'b0; end
            3'd4, 3'd6: begin w_aSigned = 1'b1; w_bSigned = 1'b1; end
            default:    begin w_aSigned = 1'b0; w_bSigned = 1'b0; end
        endcase
    end

    assign w_aNeg = w_aSigned && data_in_1[XLEN-1];
    assign w_bNeg = w_bSigned && data_in_2[XLEN-1];
    assign w_magA = w_aNeg ? (~data_in_1 + 1'b1) : data_in_1;
    assign w_magB = w_bNeg ? (~data_in_2 + 1'b1) : data_in_2;

    // -----------------------------------------------------------------------
    // One iteration step.
    // Multiply: r_acc = {partial product, remaining multiplier bits}. The
    //   multiplicand is added into the high half when the multiplier LSB is
    //   set, and then the whole register shifts right.
    // Divide: r_acc = {partial remainder, dividend/quotient}. This is a
    //   restoring divide. Because the remainder is always below the divisor,
    //   the shifted remainder stays below twice the divisor. So bit XLEN of
    //   the (XLEN+1)-bit difference is a reliable borrow. With a zero divisor
    //   the borrow is never set, and taking the difference equals keeping the
    //   shifted value. That case's quotient is overridden at write-back anyway.
    // -----------------------------------------------------------------------
    assign w_hi       = r_acc[2*XLEN-1:XLEN];
    assign w_lo       = r_acc[XLEN-1:0];
    assign w_mulSum   = {1'b0, w_hi} + (w_lo[0] ? {1'b0, r_opM} : {(XLEN+1){1'b0}});
    assign w_mulNext  = {w_mulSum, w_lo[XLEN-1:1]};
    assign w_remShift = {w_hi, w_lo[XLEN-1]};
    assign w_remDiff  = w_remShift - {1'b0, r_opM};
    assign w_divNext  = w_remDiff[XLEN] ? {w_remShift[XLEN-1:0], w_lo[XLEN-2:0], 1'b0}
                                        : {w_remDiff[XLEN-1:0],  w_lo[XLEN-2:0], 1'b1};

    // -----------------------------------------------------------------------
    // Write-back value: apply the sign and pick the half or quotient/remainder.
    // The remainder takes the dividend's sign. A zero divisor yields an
    // all-ones quotient and remainder = A, which the magnitude path already
    // produces for the remainder.
    // -----------------------------------------------------------------------
    assign w_prod = r_negRes ? (~r_acc + 1'b1) : r_acc;
    assign w_quot = r_divZero ? {XLEN{1'b1}} : (r_negRes ? (~w_lo + 1'b1) : w_lo);
    assign w_rem  = r_negA ? (~w_hi + 1'b1) : w_hi;

    always_comb begin
        w_mdRes = '0;
        case (r_mdSel)
            3'd0:             w_mdRes = w_prod[XLEN-1:0];
            3'd1, 3'd2, 3'd3: w_mdRes = w_prod[2*XLEN-1:XLEN];
            3'd4, 3'd5:       w_mdRes = w_quot;
            default:          w_mdRes = w_rem;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // -----------------------------------------------------------------------
    // FSM next state and handshake outputs. Flush overrides every transition.
    // -----------------------------------------------------------------------
    always_comb begin
        w_nextState = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;

        in_ready  = !flush && (r_state != ITER) && ((r_state == IDLE) || out_ready);
        out_valid = (r_state == DONE);
        busy      = (r_state == ITER);

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_nextState = w_isMulDiv ? ITER : DONE;
                end
            end
            ITER: begin
                if (r_count == FINAL_COUNT) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    if (w_accept) begin
                        w_nextState = w_isMulDiv ? ITER : DONE;
                    end else begin
                        w_nextState = IDLE;
                    end
                end
            end
            default: w_nextState = IDLE;
        endcase

        if (flush) begin
            w_nextState = IDLE;
        end
    end

    // -----------------------------------------------------------------------
    // Datapath registers.
    // A single-cycle op writes the slot directly. A mul/div op loads the
    // iterative unit and parks its flags and tag until write-back. A flush
    // leaves the slot contents alone; only the state machine drops them.
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_acc     <= '0;
            r_opM     <= '0;
            r_mdSel   <= '0;
            r_negRes  <= 1'b0;
            r_negA    <= 1'b0;
            r_divZero <= 1'b0;
            r_count   <= '0;
            r_pZero   <= 1'b0;
            r_pLt     <= 1'b0;
            r_pLtu    <= 1'b0;
            r_pTag    <= '0;
            r_dataOut <= '0;
            r_zero    <= 1'b0;
            r_lt      <= 1'b0;
            r_ltu     <= 1'b0;
            r_tag     <= '0;
        end else if (w_accept) begin
            if (w_isMulDiv) begin
                r_mdSel   <= w_mdSel;
                r_negRes  <= w_aNeg ^ w_bNeg;
                r_negA    <= w_aNeg;
                r_divZero <= (data_in_2 == '0);
                r_count   <= '0;
                r_pZero   <= w_zero;
                r_pLt     <= w_lt;
                r_pLtu    <= w_ltu;
                r_pTag    <= tag_in;
                if (w_mdSel[2]) begin
                    r_acc <= {{XLEN{1'b0}}, w_magA};
                    r_opM <= w_magB;
                end else begin
                    r_acc <= {{XLEN{1'b0}}, w_magB};
                    r_opM <= w_magA;
                end
            end else begin
                r_dataOut <= w_aluRes;
                r_zero    <= w_zero;
                r_lt      <= w_lt;
                r_ltu     <= w_ltu;
                r_tag     <= tag_in;
            end
        end else if ((r_state == ITER) && !flush) begin
            if (r_count == FINAL_COUNT) begin
                r_dataOut <= w_mdRes;
                r_zero    <= r_pZero;
                r_lt      <= r_pLt;
                r_ltu     <= r_pLtu;
                r_tag     <= r_pTag;
            end else begin
                r_acc   <= r_mdSel[2] ? w_divNext : w_mulNext;
                r_count <= r_count + CW'(1);
            end
        end
    end

    assign data_out = r_dataOut;
    assign zero     = r_zero;
    assign lt       = r_lt;
    assign ltu      = r_ltu;
    assign tag_out  = r_tag;

endmodule
